// File: rtl/seq_stream_monitor_if.sv
// Signal bundle between the serial stream source / result consumer and seq_stream_monitor.
interface seq_stream_monitor_if #(
  parameter int CNT_W = 5
);
  logic             din;
  logic             din_vld;
  logic             clr;
  logic             match;
  logic [CNT_W-1:0] res_cnt;
  logic             res_vld;
  logic             res_rdy;
  logic             ovf;

  modport master (
    output din, din_vld, clr, res_rdy,
    input  match, res_cnt, res_vld, ovf
  );

  modport slave (
    input  din, din_vld, clr, res_rdy,
    output match, res_cnt, res_vld, ovf
  );
endinterface

// File: rtl/seq_stream_monitor.sv
// Overlapping serial pattern detector with per-window match counting and a
// valid/ready result register that flags dropped results with a sticky ovf.
module seq_stream_monitor #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int               WIN     = 16,
  parameter int               CNT_W   = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  seq_stream_monitor_if.slave bus
);

  localparam logic [3:0]       FILL_MAX = 4'(PAT_W);
  localparam logic [7:0]       WIN_LAST = 8'(WIN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [3:0]       fill_q, fill_d;
  logic [7:0]       pos_q, pos_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] offer;
  logic             match_q, match_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic             res_vld_q, res_vld_d;
  logic             ovf_q, ovf_d;
  logic             hit;
  logic             win_end;

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pos_d     = pos_q;
    wcnt_d    = wcnt_q;
    match_d   = 1'b0;
    res_cnt_d = res_cnt_q;
    res_vld_d = res_vld_q;
    ovf_d     = ovf_q;
    hit       = 1'b0;
    win_end   = 1'b0;
    offer     = wcnt_q;

    if (bus.clr) begin
      hist_d    = '0;
      fill_d    = '0;
      pos_d     = '0;
      wcnt_d    = '0;
      res_cnt_d = '0;
      res_vld_d = 1'b0;
      ovf_d     = 1'b0;
    end else begin
      if (bus.din_vld) begin
        hist_d = {hist_q[PAT_W-2:0], bus.din};
        if (fill_q != FILL_MAX) fill_d = fill_q + 4'd1;
        hit     = (hist_d == PATTERN) && (fill_d == FILL_MAX);
        match_d = hit;
        // A match on the window's final bit still belongs to that window.
        offer   = (hit && (wcnt_q != CNT_MAX)) ? wcnt_q + 1'b1 : wcnt_q;
        if (pos_q == WIN_LAST) begin
          win_end = 1'b1;
          pos_d   = '0;
          wcnt_d  = '0;
        end else begin
          pos_d  = pos_q + 8'd1;
          wcnt_d = offer;
        end
      end

      if (win_end) begin
        if (!res_vld_q || bus.res_rdy) begin
          res_cnt_d = offer;
          res_vld_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (res_vld_q && bus.res_rdy) begin
        res_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pos_q     <= '0;
      wcnt_q    <= '0;
      match_q   <= 1'b0;
      res_cnt_q <= '0;
      res_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pos_q     <= pos_d;
      wcnt_q    <= wcnt_d;
      match_q   <= match_d;
      res_cnt_q <= res_cnt_d;
      res_vld_q <= res_vld_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.match   = match_q;
  assign bus.res_cnt = res_cnt_q;
  assign bus.res_vld = res_vld_q;
  assign bus.ovf     = ovf_q;

endmodule
